// File: rtl/seq_pattern_pkg.sv
// Shared types and constants for the serial pattern generator and its detector benches.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pattern_pkg;

    // Default parameter values for the generator.
    localparam int SPG_PAT_W = 4;
    localparam int SPG_CNT_W = 4;
    localparam int SPG_GAP_W = 4;

    // Canonical sequence the detectors look for.
    localparam logic [3:0] DET_PATTERN = 4'b1101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } spg_state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB first, zero-filled from the LSB end.
// Latency: dout reflects a load or shift at the same clock edge (registered MSB).
// Backpressure: none; load has priority over shift, neither enable holds the contents.
//
// Ports: clk, restn (async active-low), load/shift enables, din parallel word,
//        dout = current MSB.
module piso_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         restn,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] sr;

    always_ff @(posedge clk or negedge restn) begin
        if (!restn) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[W-2:0], 1'b0};
        end
    end

    assign dout = sr[W-1];

endmodule

// File: rtl/sequence_pattern_generator.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated with optional gaps.
// Latency: start sampled at edge E0 drives bit 0 from E0; done pulses at the edge after the last bit.
// Backpressure: none downstream; start is ignored while busy, abort cancels any frame in flight.
//
// Ports: clk, restn (async active-low), start, abort, pattern, repeat_n (frames-1),
//        gap (idle cycles between frames) -> out, out_valid, busy, done.
module sequence_pattern_generator
    import seq_pattern_pkg::*;
#(
    parameter int PAT_W = SPG_PAT_W,
    parameter int CNT_W = SPG_CNT_W,
    parameter int GAP_W = SPG_GAP_W
) (
    input  logic             clk,
    input  logic             restn,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [CNT_W-1:0] FRM_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    spg_state_t       state;
    logic [PAT_W-1:0] pat_lat;
    logic [GAP_W-1:0] gap_lat;
    logic [BIT_W-1:0] bit_cnt;   // index of the bit currently on the line
    logic [CNT_W-1:0] frm_cnt;   // frames still to send after the current one
    logic [GAP_W-1:0] gap_cnt;   // gap cycles left after the current one

    logic             last_bit;
    logic             sr_load;
    logic             sr_shift;
    logic [PAT_W-1:0] sr_din;

    assign last_bit = (bit_cnt == BIT_LAST);

    // Shift-register control. The register drains to zero as the last bit is
    // shifted out, so out is already 0 in GAP and after done; abort loads zero
    // explicitly because it can happen mid-frame.
    always_comb begin
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_din   = pat_lat;
        case (state)
            IDLE: begin
                if (start) begin
                    sr_load = 1'b1;
                    sr_din  = pattern;
                end
            end
            SHIFT: begin
                if (abort) begin
                    sr_load = 1'b1;
                    sr_din  = '0;
                end else if (last_bit && (frm_cnt != '0) && (gap_lat == '0)) begin
                    sr_load = 1'b1;
                end else begin
                    sr_shift = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    sr_load = 1'b1;
                    sr_din  = '0;
                end else if (gap_cnt == '0) begin
                    sr_load = 1'b1;
                end
            end
            default: begin
                sr_load = 1'b1;
                sr_din  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge restn) begin
        if (!restn) begin
            state     <= IDLE;
            pat_lat   <= '0;
            gap_lat   <= '0;
            bit_cnt   <= '0;
            frm_cnt   <= '0;
            gap_cnt   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SHIFT;
                        pat_lat   <= pattern;
                        gap_lat   <= gap;
                        frm_cnt   <= repeat_n;
                        bit_cnt   <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        frm_cnt   <= '0;
                        gap_cnt   <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (last_bit) begin
                        bit_cnt <= '0;
                        if (frm_cnt == '0) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            frm_cnt <= frm_cnt - FRM_ONE;
                            if (gap_lat != '0) begin
                                // Count the remaining gap cycles so the
                                // terminal value 0 marks the last one.
                                state     <= GAP;
                                gap_cnt   <= gap_lat - GAP_ONE;
                                out_valid <= 1'b0;
                            end
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_ONE;
                    end
                end
                GAP: begin
                    if (abort) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        frm_cnt   <= '0;
                        gap_cnt   <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (gap_cnt == '0) begin
                        state     <= SHIFT;
                        bit_cnt   <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    piso_shift_reg #(.W(PAT_W)) u_piso (
        .clk   (clk),
        .restn (restn),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (sr_din),
        .dout  (out)
    );

endmodule

// File: tb/tb_sequence_pattern_generator.sv
module tb_sequence_pattern_generator;
    import seq_pattern_pkg::*;

    localparam int PW = 4;

    logic       clk;
    logic       restn;
    logic       start;
    logic       abort;
    logic [3:0] pattern;
    logic [3:0] repeat_n;
    logic [3:0] gap;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;

    sequence_pattern_generator #(.PAT_W(4), .CNT_W(4), .GAP_W(4)) dut (
        .clk       (clk),
        .restn     (restn),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .repeat_n  (repeat_n),
        .gap       (gap),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Expected {out, out_valid, busy, done} for the cycle following edge 'cyc'.
    typedef struct {
        int         cyc;
        logic [3:0] v;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc < cyc)
                    chk("sb_order", 32'(e.cyc), 32'(cyc));
                else
                    chk("sb_out", 32'({out, out_valid, busy, done}), 32'(e.v));
            end
        end
    end

    // Reference detector on the serial line: counts 1101 windows.
    bit         det_en = 1'b0;
    logic [3:0] win;
    int         det_hits;
    always @(negedge clk) begin
        if (!det_en) begin
            win      = 4'b0000;
            det_hits = 0;
        end else begin
            win = {win[2:0], out};
            if (win == DET_PATTERN) begin
                det_hits++;
                chk("det_on_valid", 32'(out_valid), 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Build the expected output stream for one transaction starting at 'base'.
    task automatic push_exp(input logic [3:0] pat, input logic [3:0] rep, input logic [3:0] g,
                            input int base, input int abort_at, output int end_cyc);
        int   n;
        exp_t e;
        n = 0;
        for (int f = 0; f <= int'(rep); f++) begin
            for (int b = PW - 1; b >= 0; b--) begin
                if (n == abort_at) begin
                    e.cyc = base + n;     e.v = 4'b0000; exp_q.push_back(e);
                    e.cyc = base + n + 1; e.v = 4'b0000; exp_q.push_back(e);
                    end_cyc = base + n;
                    return;
                end
                e.cyc = base + n; e.v = {pat[b], 1'b1, 1'b1, 1'b0}; exp_q.push_back(e);
                n++;
            end
            if (f < int'(rep)) begin
                for (int k = 0; k < int'(g); k++) begin
                    e.cyc = base + n; e.v = 4'b0010; exp_q.push_back(e);
                    n++;
                end
            end
        end
        e.cyc = base + n; e.v = 4'b0001; exp_q.push_back(e);
        end_cyc = base + n;
    endtask

    // Called just after a rising edge; start is sampled at the next edge.
    task automatic send(input logic [3:0] pat, input logic [3:0] rep, input logic [3:0] g,
                        input int abort_at, output int end_cyc);
        pattern  = pat;
        repeat_n = rep;
        gap      = g;
        start    = 1'b1;
        push_exp(pat, rep, g, cyc + 1, abort_at, end_cyc);
        step();
        start    = 1'b0;
        pattern  = 4'($urandom);
        repeat_n = 4'($urandom);
        gap      = 4'($urandom);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 2000) begin
            step();
            budget++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
        chk("idle_after", 32'({out, out_valid, busy, done}), 32'd0);
        step();
    endtask

    int d;

    initial begin
        restn    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        pattern  = '0;
        repeat_n = '0;
        gap      = '0;
        #2;
        chk("reset_out", 32'({out, out_valid, busy, done}), 32'd0);
        step();
        restn = 1'b1;
        step();
        chk("idle_post_reset", 32'({out, out_valid, busy, done}), 32'd0);
        mon_en = 1'b1;

        // Single frame, no repeat
        send(DET_PATTERN, 4'd0, 4'd0, -1, d);
        drain();

        // Two frames separated by a 2-cycle gap
        send(DET_PATTERN, 4'd1, 4'd2, -1, d);
        drain();

        // Contiguous frames, then a start aligned with the done cycle
        send(DET_PATTERN, 4'd2, 4'd0, -1, d);
        while (cyc < d) step();
        send(4'b1010, 4'd0, 4'd1, -1, d);
        drain();

        // Start pulsed mid-frame with a different pattern is ignored
        send(4'b0110, 4'd0, 4'd0, -1, d);
        pattern = 4'b1111;
        start   = 1'b1;
        step();
        start   = 1'b0;
        drain();

        // Abort while bit 2 is on the line: idle at next edge, no done
        send(DET_PATTERN, 4'd2, 4'd0, 3, d);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        drain();

        // Abort together with start in IDLE: start wins
        abort = 1'b1;
        send(4'b1001, 4'd0, 4'd0, -1, d);
        abort = 1'b0;
        drain();

        // Asynchronous reset in the middle of a gap
        begin
            int base;
            base = cyc + 1;
            send(DET_PATTERN, 4'd1, 4'd3, -1, d);
            while (cyc < base + 4) step();
            #2;
            mon_en = 1'b0;
            exp_q.delete();
            restn = 1'b0;
            #1;
            chk("async_reset", 32'({out, out_valid, busy, done}), 32'd0);
            step();
            step();
            restn = 1'b1;
            @(negedge clk);
            chk("reset_release", 32'({out, out_valid, busy, done}), 32'd0);
            step();
            mon_en = 1'b1;
            send(DET_PATTERN, 4'd0, 4'd0, -1, d);
            drain();
        end

        // Loopback into a reference 1101 detector
        det_en = 1'b1;
        send(DET_PATTERN, 4'd3, 4'd1, -1, d);
        drain();
        chk("det_hits", 32'(det_hits), 32'd4);
        det_en = 1'b0;

        // Random configurations
        for (int i = 0; i < 3; i++) begin
            send(4'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), -1, d);
            drain();
        end

        // Maximum repeat count and gap
        send(4'b1001, 4'd15, 4'd15, -1, d);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
